// File: rtl/mult_accumulator_if.sv
// Product-in / group-sum-out bundle for mult_accumulator.
// The DUT connects through the slave modport and the producer/consumer side through the master modport.
interface mult_accumulator_if #(
  parameter int DATAWIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int NUM_TERMS = 8
);
  localparam int CW = $clog2(NUM_TERMS + 1);

  logic                   i_valid;
  logic [2*DATAWIDTH-1:0] i_product;
  logic                   i_clear;
  logic                   o_valid;
  logic                   o_ready;
  logic [ACC_WIDTH-1:0]   o_sum;
  logic                   o_overflow;
  logic                   o_drop;
  logic [CW-1:0]          o_count;

  modport master (
    output i_valid, i_product, i_clear, o_ready,
    input  o_valid, o_sum, o_overflow, o_drop, o_count
  );

  modport slave (
    input  i_valid, i_product, i_clear, o_ready,
    output o_valid, o_sum, o_overflow, o_drop, o_count
  );
endinterface

// File: rtl/mult_accumulator.sv
// Sums groups of NUM_TERMS unsigned products into a one-entry valid/ready result slot.
// Define MULT_ACC_SATURATE_EN to clamp the group sum on overflow instead of wrapping.
module mult_accumulator #(
  parameter int DATAWIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int NUM_TERMS = 8
) (
  input logic               clk,
  input logic               rst,
  mult_accumulator_if.slave bus
);
  localparam int PW = 2 * DATAWIDTH;
  localparam int CW = $clog2(NUM_TERMS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_TERMS - 1);

  // Returns {overflow, new accumulator}; overflow is sticky across the group.
  function automatic logic [ACC_WIDTH:0] add_term(
    input logic [ACC_WIDTH-1:0] base,
    input logic                 ovf_in,
    input logic [PW-1:0]        prod
  );
    logic [ACC_WIDTH:0] s;
    logic               ovf;
    s   = {1'b0, base} + {{(ACC_WIDTH + 1 - PW){1'b0}}, prod};
    ovf = ovf_in | s[ACC_WIDTH];
`ifdef MULT_ACC_SATURATE_EN
    if (ovf) return {1'b1, {ACC_WIDTH{1'b1}}};
`endif
    return {ovf, s[ACC_WIDTH-1:0]};
  endfunction

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_acc_q, ovf_acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 valid_q, valid_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                 ovf_out_q, ovf_out_d;
  logic                 drop_q, drop_d;

  logic [ACC_WIDTH-1:0] base_acc;
  logic                 base_ovf;
  logic [CW-1:0]        base_cnt;
  logic [ACC_WIDTH:0]   next_term;
  logic                 done;
  logic                 slot_free;

  always_comb begin
    // i_clear restarts the group before the current product is applied
    base_acc  = bus.i_clear ? '0 : acc_q;
    base_ovf  = bus.i_clear ? 1'b0 : ovf_acc_q;
    base_cnt  = bus.i_clear ? '0 : count_q;
    next_term = add_term(base_acc, base_ovf, bus.i_product);
    done      = bus.i_valid && (base_cnt == LAST_CNT);
    slot_free = !valid_q || bus.o_ready;

    acc_d     = base_acc;
    ovf_acc_d = base_ovf;
    count_d   = base_cnt;
    if (bus.i_valid) begin
      if (done) begin
        acc_d     = '0;
        ovf_acc_d = 1'b0;
        count_d   = '0;
      end else begin
        acc_d     = next_term[ACC_WIDTH-1:0];
        ovf_acc_d = next_term[ACC_WIDTH];
        count_d   = CW'(base_cnt + 1'b1);
      end
    end

    valid_d   = valid_q && !bus.o_ready;
    sum_d     = sum_q;
    ovf_out_d = ovf_out_q;
    drop_d    = bus.i_clear ? 1'b0 : drop_q;
    if (done) begin
      if (slot_free) begin
        valid_d   = 1'b1;
        sum_d     = next_term[ACC_WIDTH-1:0];
        ovf_out_d = next_term[ACC_WIDTH];
      end else begin
        drop_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      sum_q     <= '0;
      ovf_out_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      sum_q     <= sum_d;
      ovf_out_q <= ovf_out_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_sum      = sum_q;
  assign bus.o_overflow = ovf_out_q;
  assign bus.o_drop     = drop_q;
  assign bus.o_count    = count_q;
endmodule
